// File: rtl/parking_timestamp_log_if.sv
// Gate and billing-side signal bundle for parking_timestamp_log.
// master drives the gate requests, slave (the logger) returns the records and status.
interface parking_timestamp_log_if #(
  parameter int unsigned SW = 2,
  parameter int unsigned TW = 8
);
  logic          entry_req;
  logic          entry_ack;
  logic          entry_err;
  logic [SW-1:0] entry_slot;
  logic          exit_req;
  logic [SW-1:0] exit_slot;
  logic          out_valid;
  logic          exit_err;
  logic [TW-1:0] time_in;
  logic [TW-1:0] time_out;
  logic [TW-1:0] time_total;
  logic [TW-1:0] cur_time;
  logic [SW:0]   occupancy;
  logic          full;
  logic          overstay;

  modport master (
    output entry_req, exit_req, exit_slot,
    input  entry_ack, entry_err, entry_slot, out_valid, exit_err, time_in, time_out,
           time_total, cur_time, occupancy, full, overstay
  );

  modport slave (
    input  entry_req, exit_req, exit_slot,
    output entry_ack, entry_err, entry_slot, out_valid, exit_err, time_in, time_out,
           time_total, cur_time, occupancy, full, overstay
  );
endinterface

// File: rtl/parking_timestamp_log.sv
// Parking lot time base, per-slot entry stamps and exit duration records.
// Optional overstay flag enabled by defining PARK_OVERSTAY_EN.
module parking_timestamp_log #(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned SW       = 2,
  parameter int unsigned TW       = 8,
  parameter int unsigned TICK_DIV = 16,
  parameter int unsigned MAX_STAY = 200
) (
  input logic                   clk,
  input logic                   rst_n,
  parking_timestamp_log_if.slave park_io
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    pre_q, pre_d;
  logic [TW-1:0]    cur_time_q, cur_time_d;
  logic [SLOTS-1:0] occ_q, occ_d;
  logic [SW:0]      cnt_q, cnt_d;
  logic [TW-1:0]    stamp_q [SLOTS];

  logic          entry_ack_q, entry_err_q, out_valid_q, exit_err_q;
  logic [SW-1:0] entry_slot_q;
  logic [TW-1:0] time_in_q, time_out_q, time_total_q;

  logic          tick, full, entry_ok, exit_ok, free_found, exit_hit;
  logic [SW-1:0] free_idx;
  logic [TW-1:0] exit_stamp, total_d;

  assign full = (cnt_q == (SW+1)'(SLOTS));
  assign tick = (pre_q == PW'(TICK_DIV - 1));

  // Downward scan so the lowest-index free slot wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    exit_hit   = 1'b0;
    exit_stamp = '0;
    for (int i = 0; i < int'(SLOTS); i++) begin
      if (park_io.exit_slot == SW'(i) && occ_q[i]) begin
        exit_hit   = 1'b1;
        exit_stamp = stamp_q[i];
      end
    end
  end

  always_comb begin
    entry_ok   = park_io.entry_req && !full && free_found;
    exit_ok    = park_io.exit_req && exit_hit;
    total_d    = cur_time_q - exit_stamp;
    pre_d      = tick ? '0 : pre_q + PW'(1);
    cur_time_d = tick ? cur_time_q + TW'(1) : cur_time_q;
    // Allocation decided from pre-edge occupancy, so a slot freed this edge stays free.
    occ_d      = occ_q;
    if (exit_ok) begin
      occ_d[park_io.exit_slot] = 1'b0;
    end
    if (entry_ok) begin
      occ_d[free_idx] = 1'b1;
    end
    cnt_d = cnt_q + (SW+1)'(entry_ok) - (SW+1)'(exit_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      cur_time_q   <= '0;
      occ_q        <= '0;
      cnt_q        <= '0;
      entry_ack_q  <= 1'b0;
      entry_err_q  <= 1'b0;
      entry_slot_q <= '0;
      out_valid_q  <= 1'b0;
      exit_err_q   <= 1'b0;
      time_in_q    <= '0;
      time_out_q   <= '0;
      time_total_q <= '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        stamp_q[i] <= '0;
      end
    end else begin
      pre_q       <= pre_d;
      cur_time_q  <= cur_time_d;
      occ_q       <= occ_d;
      cnt_q       <= cnt_d;
      entry_ack_q <= entry_ok;
      entry_err_q <= park_io.entry_req && !entry_ok;
      out_valid_q <= exit_ok;
      exit_err_q  <= park_io.exit_req && !exit_ok;
      if (entry_ok) begin
        entry_slot_q <= free_idx;
      end
      if (exit_ok) begin
        time_in_q    <= exit_stamp;
        time_out_q   <= cur_time_q;
        time_total_q <= total_d;
      end
      for (int i = 0; i < int'(SLOTS); i++) begin
        if (entry_ok && free_idx == SW'(i)) begin
          stamp_q[i] <= cur_time_q;
        end
      end
    end
  end

`ifdef PARK_OVERSTAY_EN
  logic overstay_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overstay_q <= 1'b0;
    end else begin
      overstay_q <= exit_ok && (32'(total_d) >= MAX_STAY);
    end
  end

  assign park_io.overstay = overstay_q;
`else
  assign park_io.overstay = 1'b0;
`endif

  assign park_io.entry_ack  = entry_ack_q;
  assign park_io.entry_err  = entry_err_q;
  assign park_io.entry_slot = entry_slot_q;
  assign park_io.out_valid  = out_valid_q;
  assign park_io.exit_err   = exit_err_q;
  assign park_io.time_in    = time_in_q;
  assign park_io.time_out   = time_out_q;
  assign park_io.time_total = time_total_q;
  assign park_io.cur_time   = cur_time_q;
  assign park_io.occupancy  = cnt_q;
  assign park_io.full       = full;

endmodule
